// File: rtl/pipe_skid_reg_pkg.sv
// pipe_skid_reg_pkg
//   Shared definitions for every pipeline-stage register instance:
//   default payload width, NOP/BUBBLE encoding, the occupancy state
//   encoding and small helpers that derive handshake flags from occupancy.
package pipe_skid_reg_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam logic [DEF_WIDTH-1:0] DEF_BUBBLE = {DEF_WIDTH{1'b0}};

  // Occupancy doubles as the control state; 2'b11 is never entered.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // The stage can take a new payload unless both entries are held.
  function automatic logic can_accept(input occ_e occ);
    return (occ != OCC_FULL);
  endfunction

  // A head entry exists whenever the stage is not empty.
  function automatic logic has_head(input occ_e occ);
    return (occ != OCC_EMPTY);
  endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// pipe_skid_reg_if
//   Handshake bundle between two pipeline stages.
//   In_Valid/In_Ready/In_Data : upstream -> stage
//   Out_Valid/Out_Ready/Out_Data : stage -> downstream
//   Occupancy : number of entries held by the stage (0..2)
//   slave  : view of the stage register itself
//   master : view of the environment (upstream producer + downstream consumer)
interface pipe_skid_reg_if
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) ();

  logic             In_Valid;
  logic             In_Ready;
  logic [WIDTH-1:0] In_Data;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [WIDTH-1:0] Out_Data;
  logic [1:0]       Occupancy;

  modport slave (
    input  In_Valid, In_Data, Out_Ready,
    output In_Ready, Out_Valid, Out_Data, Occupancy
  );

  modport master (
    output In_Valid, In_Data, Out_Ready,
    input  In_Ready, Out_Valid, Out_Data, Occupancy
  );

endinterface

// File: rtl/pipe_skid_reg_reg_en.sv
// pipe_reg_en
//   Generic WIDTH-bit register with synchronous active-high reset to RST_VAL
//   and a load enable; holds its value whenever en is low.
//   clk   : rising-edge clock
//   rst   : synchronous reset, active-high
//   en    : load d on the next edge
//   d / q : data in / registered data out
module pipe_reg_en #(
  parameter int unsigned       WIDTH   = 32,
  parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;

  // Storage flop: reset wins, otherwise load only when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= RST_VAL;
    end else if (en) begin
      data_q <= d;
    end else begin
      data_q <= data_q;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
//   Pipeline-stage register with valid/ready handshake and a 2-entry skid
//   buffer so In_Ready is a flop with no path from Out_Ready.
//   Clk   : rising-edge clock
//   Rst   : synchronous reset, active-high, highest priority
//   Flush : drop all held entries; the payload offered this cycle is discarded
//   bus   : handshake bundle (slave view): In_Valid/In_Ready/In_Data,
//           Out_Valid/Out_Ready/Out_Data, Occupancy
//   Out_Data shows BUBBLE whenever Out_Valid is low.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned      WIDTH  = DEF_WIDTH,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
  input logic            Clk,
  input logic            Rst,
  input logic            Flush,
  pipe_skid_reg_if.slave bus
);

  occ_e             occ_q, occ_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             main_en, skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             accept, pop;

  assign accept = bus.In_Valid & in_ready_q;
  assign pop    = out_valid_q & bus.Out_Ready;

  // Head entry: loaded from input or shifted up from skid.
  pipe_reg_en #(.WIDTH(WIDTH), .RST_VAL(BUBBLE)) u_main (
    .clk (Clk),
    .rst (Rst),
    .en  (main_en),
    .d   (main_d),
    .q   (main_q)
  );

  // Skid entry: only ever loaded directly from the input.
  pipe_reg_en #(.WIDTH(WIDTH), .RST_VAL(BUBBLE)) u_skid (
    .clk (Clk),
    .rst (Rst),
    .en  (skid_en),
    .d   (bus.In_Data),
    .q   (skid_q)
  );

  // Control state register: occupancy plus the registered handshake flags.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      occ_q       <= OCC_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic: occupancy transitions and data-register enables.
  always_comb begin
    occ_d   = occ_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = bus.In_Data;
    if (Flush) begin
      // Squash leaves data regs untouched; Out_Data is masked to BUBBLE.
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (accept) begin
            main_en = 1'b1;
            occ_d   = OCC_ONE;
          end else begin
            occ_d = OCC_EMPTY;
          end
        end
        OCC_ONE: begin
          if (accept && pop) begin
            main_en = 1'b1;
            occ_d   = OCC_ONE;
          end else if (accept) begin
            // Head is stalled; the newer payload waits behind it.
            skid_en = 1'b1;
            occ_d   = OCC_FULL;
          end else if (pop) begin
            occ_d = OCC_EMPTY;
          end else begin
            occ_d = OCC_ONE;
          end
        end
        OCC_FULL: begin
          // In_Ready is low here, so only a pop can happen.
          if (pop) begin
            main_d  = skid_q;
            main_en = 1'b1;
            occ_d   = OCC_ONE;
          end else begin
            occ_d = OCC_FULL;
          end
        end
        default: begin
          // Illegal 2'b11 recovers to empty.
          occ_d = OCC_EMPTY;
        end
      endcase
    end
    in_ready_d  = can_accept(occ_d);
    out_valid_d = has_head(occ_d);
  end

  // Outputs: all driven from flops; the head is masked to BUBBLE when invalid.
  always_comb begin
    bus.In_Ready  = in_ready_q;
    bus.Out_Valid = out_valid_q;
    bus.Occupancy = occ_q;
    if (out_valid_q) begin
      bus.Out_Data = main_q;
    end else begin
      bus.Out_Data = BUBBLE;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg
//   Scoreboard bench: the reference model is a bounded FIFO (queue, depth 2)
//   updated on observed handshakes; a separate monitor pops and compares on
//   every downstream transfer, and a state checker compares the flags and
//   occupancy against the model queue each cycle.
module tb_pipe_skid_reg;
  import pipe_skid_reg_pkg::*;

  localparam int unsigned  W   = 32;
  localparam logic [W-1:0] BUB = {W{1'b0}};

  logic Clk = 1'b0;
  logic Rst;
  logic Flush;

  always #5 Clk = ~Clk;

  pipe_skid_reg_if #(.WIDTH(W)) bus ();

  pipe_skid_reg #(.WIDTH(W), .BUBBLE(BUB)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Flush (Flush),
    .bus   (bus.slave)
  );

  int           checks = 0;
  int           errors = 0;
  bit           chk_en = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: payloads accepted upstream enter the queue; squash empties it.
  always @(posedge Clk) begin
    if (Rst || Flush) begin
      exp_q.delete();
    end else if (bus.In_Valid && bus.In_Ready) begin
      exp_q.push_back(bus.In_Data);
    end
  end

  // Monitor: every downstream transfer must deliver the oldest outstanding payload.
  always @(posedge Clk) begin
    if (chk_en && !Rst && !Flush && bus.Out_Valid && bus.Out_Ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_empty: got %0h expected no transfer at %0t", bus.Out_Data, $time);
      end else begin
        chk("pop_data", bus.Out_Data, exp_q.pop_front());
      end
    end
  end

  // State checker: flags and occupancy follow from how many payloads are outstanding.
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("occupancy", W'(bus.Occupancy), W'(exp_q.size()));
      chk("in_ready",  W'(bus.In_Ready),  W'(exp_q.size() < 2));
      chk("out_valid", W'(bus.Out_Valid), W'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("head_data", bus.Out_Data, exp_q[0]);
      end else begin
        chk("bubble", bus.Out_Data, BUB);
      end
    end
  end

  // One cycle of stimulus, applied just after a falling edge; also confirms
  // In_Ready does not move when Out_Ready and the other inputs change.
  task automatic cyc(input logic r, input logic f, input logic iv,
                     input logic [W-1:0] d, input logic ordy);
    logic prev;
    prev          = bus.In_Ready;
    Rst           = r;
    Flush         = f;
    bus.In_Valid  = iv;
    bus.In_Data   = d;
    bus.Out_Ready = ordy;
    #1;
    if (chk_en) chk("in_ready_comb", W'(bus.In_Ready), W'(prev));
    @(negedge Clk);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_occ"},   W'(bus.Occupancy), 32'd0);
    chk({nm, "_valid"}, W'(bus.Out_Valid), 32'd0);
    chk({nm, "_data"},  bus.Out_Data,      BUB);
    chk({nm, "_ready"}, W'(bus.In_Ready),  32'd1);
  endtask

  logic [W-1:0] s2_vals[3] = '{32'h11, 32'h22, 32'h33};

  initial begin
    Rst           = 1'b1;
    Flush         = 1'b0;
    bus.In_Valid  = 1'b0;
    bus.In_Data   = 32'h0;
    bus.Out_Ready = 1'b0;
    @(negedge Clk);

    // 1: reset held two cycles
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk_en = 1'b1;
    chk_idle("s1");
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // 2: streaming with downstream always ready
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, s2_vals[i], 1'b1);
      chk("s2_data",  bus.Out_Data,      s2_vals[i]);
      chk("s2_occ",   W'(bus.Occupancy), 32'd1);
      chk("s2_ready", W'(bus.In_Ready),  32'd1);
    end
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // 3: backpressure fills the skid, then drains in order
    cyc(1'b0, 1'b0, 1'b1, 32'hA, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'hB, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'hC, 1'b0);
    chk("s3_occ",   W'(bus.Occupancy), 32'd2);
    chk("s3_ready", W'(bus.In_Ready),  32'd0);
    chk("s3_head",  bus.Out_Data,      32'hA);
    cyc(1'b0, 1'b0, 1'b1, 32'hC, 1'b1);
    chk("s3_b", bus.Out_Data, 32'hB);
    cyc(1'b0, 1'b0, 1'b1, 32'hC, 1'b1);
    chk("s3_c", bus.Out_Data, 32'hC);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_idle("s3_end");

    // 4: flush while full discards held and offered payloads
    cyc(1'b0, 1'b0, 1'b1, 32'h1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h2, 1'b0);
    chk("s4_full", W'(bus.Occupancy), 32'd2);
    cyc(1'b0, 1'b1, 1'b1, 32'hDEAD, 1'b0);
    chk_idle("s4");
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("s4_nodead", bus.Out_Data, BUB);

    // 5: reset mid-transfer while full
    cyc(1'b0, 1'b0, 1'b1, 32'h5, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h6, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 32'h7, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 32'h8, 1'b0);
    chk_idle("s5");

    // 6: random traffic with occasional flush and reset
    for (int i = 0; i < 10000; i++) begin
      cyc(($urandom_range(0, 511) == 0),
          ($urandom_range(0, 63) == 0),
          1'($urandom_range(0, 1)),
          $urandom,
          ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    end
    chk_idle("s6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
